// File: rtl/button_conditioner_if.sv
// +----------------------------------------------------------------------+
// | button_conditioner_if                                                |
// | Raw button levels in, conditioned press pulses and held levels out.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface button_conditioner_if #(
  parameter int N_BUTTONS = 7
);
  logic [N_BUTTONS-1:0] buttons_raw;
  logic [N_BUTTONS-1:0] buttons_pulse;
  logic [N_BUTTONS-1:0] buttons_held;

  modport master (output buttons_raw, input buttons_pulse, input buttons_held);
  modport slave  (input buttons_raw, output buttons_pulse, output buttons_held);
endinterface

`default_nettype wire

// File: rtl/button_conditioner.sv
// +----------------------------------------------------------------------+
// | button_conditioner                                                   |
// | Per-button synchroniser, debounce, press pulse and auto-repeat.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module button_conditioner #(
  parameter int                   N_BUTTONS       = 7,
  parameter int                   DEBOUNCE_CYCLES = 1000000,
  parameter int                   REPEAT_DELAY    = 25000000,
  parameter int                   REPEAT_PERIOD   = 5000000,
  parameter logic [N_BUTTONS-1:0] REPEAT_MASK     = 7'b0001111,
  parameter bit                   ACTIVE_LOW      = 1'b0
) (
  input wire logic            clk,
  input wire logic            reset,
  button_conditioner_if.slave btn
);

  localparam int DBW     = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

  localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]  DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]  PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  logic [N_BUTTONS-1:0] s1_q;
  logic [N_BUTTONS-1:0] s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn.buttons_raw ^ {N_BUTTONS{ACTIVE_LOW}};
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           stable_q, stable_d;
    logic           prev_q;
    logic           pulse_q, pulse_d;
    logic           press;
    logic           rep_fire;

    always_comb begin
      stable_d = stable_q;
      db_cnt_d = '0;
      if (s2_q[i] != stable_q) begin
        if (db_cnt_q == DB_LAST) begin
          stable_d = s2_q[i];
        end else begin
          db_cnt_d = db_cnt_q + DBW'(1);
        end
      end
    end

    assign press   = stable_q & ~prev_q;
    assign pulse_d = press | rep_fire;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        db_cnt_q <= '0;
        stable_q <= 1'b0;
        prev_q   <= 1'b0;
        pulse_q  <= 1'b0;
      end else begin
        db_cnt_q <= db_cnt_d;
        stable_q <= stable_d;
        prev_q   <= stable_q;
        pulse_q  <= pulse_d;
      end
    end

    if (REPEAT_MASK[i]) begin : g_rep
      rep_state_e     state_q, state_d;
      logic [RW-1:0]  rcnt_q, rcnt_d;

      // Looking at stable_d lets a release cancel a repeat due on the same edge.
      always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        rep_fire = 1'b0;
        if (!stable_d) begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (press) begin
                state_d = ST_DELAY;
                rcnt_d  = '0;
              end
            end
            ST_DELAY: begin
              if (rcnt_q == DELAY_LAST) begin
                rep_fire = 1'b1;
                state_d  = ST_REPEAT;
                rcnt_d   = '0;
              end else begin
                rcnt_d = rcnt_q + RW'(1);
              end
            end
            ST_REPEAT: begin
              if (rcnt_q == PERIOD_LAST) begin
                rep_fire = 1'b1;
                rcnt_d   = '0;
              end else begin
                rcnt_d = rcnt_q + RW'(1);
              end
            end
            default: begin
              state_d = ST_IDLE;
              rcnt_d  = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q <= ST_IDLE;
          rcnt_q  <= '0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
        end
      end
    end else begin : g_norep
      assign rep_fire = 1'b0;
    end

    assign btn.buttons_held[i]  = stable_q;
    assign btn.buttons_pulse[i] = pulse_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// +----------------------------------------------------------------------+
// | tb_button_conditioner                                                |
// | Directed and random stimulus against an edge-count reference model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_button_conditioner;

  localparam int          DEB  = 4;
  localparam int          RD   = 10;
  localparam int          RP   = 4;
  localparam logic [6:0]  MASK = 7'b0001111;

  logic clk;
  logic reset;

  button_conditioner_if #(.N_BUTTONS(7)) bif ();

  button_conditioner #(
    .N_BUTTONS      (7),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_MASK    (MASK),
    .ACTIVE_LOW     (1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: pipeline of sampled raw levels, a run length of
  // disagreeing samples per channel, and the edge at which each press began.
  logic [6:0] m_s1, m_s2, m_stable;
  int         m_run [7];
  int         m_rise[7];
  int         ecnt;
  logic [6:0] exp_held, exp_pulse;
  int         pcnt[7];

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    m_stable = '0;
    for (int ch = 0; ch < 7; ch++) begin
      m_run[ch]  = 0;
      m_rise[ch] = -1;
    end
  endtask

  task automatic model_edge(input logic [6:0] raw);
    logic [6:0] s2pre;
    int d;
    ecnt++;
    s2pre = m_s2;
    m_s2  = m_s1;
    m_s1  = raw;
    exp_pulse = '0;
    for (int ch = 0; ch < 7; ch++) begin
      if (s2pre[ch] != m_stable[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == DEB) begin
          m_stable[ch] = s2pre[ch];
          m_run[ch]    = 0;
          m_rise[ch]   = m_stable[ch] ? ecnt : -1;
        end
      end else begin
        m_run[ch] = 0;
      end
      if (m_stable[ch] && m_rise[ch] >= 0) begin
        d = ecnt - m_rise[ch] - 1;
        if (d == 0)
          exp_pulse[ch] = 1'b1;
        else if (MASK[ch] && (d == RD || (d > RD && ((d - RD) % RP) == 0)))
          exp_pulse[ch] = 1'b1;
      end
    end
    exp_held = m_stable;
  endtask

  task automatic check_outputs(input logic [6:0] eh, input logic [6:0] ep, input string tag);
    vectors++;
    assert (bif.buttons_held === eh) else begin
      miscompares++;
      $error("FAIL %s held: observed %b expected %b (edge %0d)", tag, bif.buttons_held, eh, ecnt);
    end
    vectors++;
    assert (bif.buttons_pulse === ep) else begin
      miscompares++;
      $error("FAIL %s pulse: observed %b expected %b (edge %0d)", tag, bif.buttons_pulse, ep, ecnt);
    end
  endtask

  // Called just after a falling edge; leaves time at the next falling edge.
  task automatic step(input logic [6:0] raw, input string tag);
    bif.buttons_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    check_outputs(exp_held, exp_pulse, tag);
    for (int ch = 0; ch < 7; ch++) pcnt[ch] += int'(bif.buttons_pulse[ch]);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) step(7'h00, tag);
  endtask

  initial begin
    logic [6:0] cur;
    int first;
    ecnt = 0;
    for (int ch = 0; ch < 7; ch++) pcnt[ch] = 0;
    model_reset();
    reset = 1'b1;
    bif.buttons_raw = '0;

    // Reset held with random inputs
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      bif.buttons_raw = 7'($urandom);
      @(posedge clk);
      #1;
      check_outputs(7'h00, 7'h00, "in_reset");
      @(negedge clk);
    end
    bif.buttons_raw = '0;
    reset = 1'b0;
    idle(5, "post_reset");

    // Clean press on start
    for (int k = 0; k < 14; k++) step(7'h10, "start_press");
    idle(10, "start_release");

    // Bouncing a, then a clean press
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) step(7'h20, "bounce");
      for (int k = 0; k < 3; k++) step(7'h00, "bounce");
    end
    idle(8, "bounce_low");
    pcnt[5] = 0;
    for (int k = 0; k < 20; k++) step(7'h20, "a_press");
    idle(8, "a_release");
    vectors++;
    assert (pcnt[5] == 1) else begin
      miscompares++;
      $error("FAIL a_pulse_count: observed %0d expected 1", pcnt[5]);
    end

    // Auto-repeat on up
    for (int k = 0; k < 40; k++) step(7'h01, "up_repeat");
    idle(10, "up_release");

    // Simultaneous down and b
    for (int k = 0; k < 30; k++) step(7'h42, "down_b");
    idle(10, "down_b_release");

    // Async reset during repeat on left
    for (int k = 0; k < 25; k++) step(7'h04, "left_repeat");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs(7'h00, 7'h00, "async_clear");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_outputs(7'h00, 7'h00, "left_in_reset");
    end
    @(negedge clk);
    reset = 1'b0;
    first = 0;
    for (int k = 1; k <= 15; k++) begin
      step(7'h04, "left_requalify");
      if (first == 0 && bif.buttons_pulse[2]) first = k;
    end
    vectors++;
    assert (first == 7) else begin
      miscompares++;
      $error("FAIL left_repress_latency: observed %0d expected 7", first);
    end
    idle(10, "left_release");

    // Random slowly-toggling inputs
    cur = '0;
    for (int k = 0; k < 600; k++) begin
      for (int ch = 0; ch < 7; ch++)
        if ($urandom_range(0, 9) == 0) cur[ch] = ~cur[ch];
      step(cur, "random");
    end
    idle(10, "final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
